// File: rtl/uart_display_pkg.sv
// Shared constants for the UART byte display: segment glyphs, blank pattern
// and history depth.
package uart_display_pkg;

    localparam logic [6:0] seg_blank     = 7'h7F;
    localparam int         history_depth = 3;

    // Active-low segments, bit6=g .. bit0=a, indexed by nibble value.
    localparam logic [6:0] seg_glyph [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

endpackage

// File: rtl/uart_byte_display_if.sv
// Byte strobe bus from the UART receiver into the display.
// byte_ready is a single-cycle strobe; byte_data is meaningful only while it
// is high, and there is no back-pressure (the consumer always accepts).
interface uart_byte_display_if;

    logic [7:0] byte_data;
    logic       byte_ready;

    modport master (output byte_data, output byte_ready);
    modport slave  (input  byte_data, input  byte_ready);

endinterface

// File: rtl/hex_to_seven_seg.sv
// Combinational nibble to active-low seven-segment decode; blank when the
// owning history slot is not valid.
module hex_to_seven_seg
    import uart_display_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       valid,
    output logic [6:0] seg
);

    assign seg = valid ? seg_glyph[nibble] : seg_blank;

endmodule

// File: rtl/uart_byte_display.sv
// Three-byte receive history shown as hex on six digits, plus a wrapping
// byte counter and a pulse-stretched activity LED.
module uart_byte_display
    import uart_display_pkg::*;
#(
    parameter int activity_cycles = 5000000
) (
    input  logic                  clock,
    input  logic                  reset_n,
    uart_byte_display_if.slave    bus,
    input  logic                  clear,
    input  logic                  hold,
    output logic [6:0]            hex0,
    output logic [6:0]            hex1,
    output logic [6:0]            hex2,
    output logic [6:0]            hex3,
    output logic [6:0]            hex4,
    output logic [6:0]            hex5,
    output logic [7:0]            byte_count,
    output logic                  led_activity
);

    localparam int                    stretch_w    = $clog2(activity_cycles + 1);
    localparam logic [stretch_w-1:0]  stretch_load = stretch_w'(activity_cycles);

    logic [7:0]               hist [history_depth];
    logic [history_depth-1:0] valid;
    logic [stretch_w-1:0]     stretch;
    logic [6:0]               seg_next [6];
    logic [6:0]               seg_q    [6];

    // Digit 2k is the low nibble and digit 2k+1 the high nibble of slot k.
    for (genvar i = 0; i < 6; i++) begin : g_digit
        hex_to_seven_seg u_dec (
            .nibble (hist[i/2][(i%2)*4 +: 4]),
            .valid  (valid[i/2]),
            .seg    (seg_next[i])
        );
    end

    // Clear wins over hold: a strobe coinciding with clear restarts the
    // history with just that byte, whatever hold says.
    always_ff @(posedge clock or posedge reset_n) begin
        if (reset_n) begin
            for (int i = 0; i < history_depth; i++) hist[i] <= '0;
            valid      <= '0;
            byte_count <= '0;
        end else if (clear && bus.byte_ready) begin
            hist[0]    <= bus.byte_data;
            valid      <= history_depth'(1);
            byte_count <= 8'd1;
        end else if (clear) begin
            valid      <= '0;
            byte_count <= '0;
        end else if (bus.byte_ready) begin
            byte_count <= byte_count + 8'd1;
            if (!hold) begin
                for (int i = history_depth - 1; i > 0; i--) hist[i] <= hist[i-1];
                hist[0] <= bus.byte_data;
                valid   <= {valid[history_depth-2:0], 1'b1};
            end
        end
    end

    always_ff @(posedge clock or posedge reset_n) begin
        if (reset_n) begin
            stretch      <= '0;
            led_activity <= 1'b0;
        end else begin
            if (bus.byte_ready)      stretch <= stretch_load;
            else if (stretch != '0)  stretch <= stretch - 1'b1;
            led_activity <= (stretch != '0);
        end
    end

    always_ff @(posedge clock or posedge reset_n) begin
        if (reset_n) begin
            for (int i = 0; i < 6; i++) seg_q[i] <= seg_blank;
        end else begin
            for (int i = 0; i < 6; i++) seg_q[i] <= seg_next[i];
        end
    end

    assign hex0 = seg_q[0];
    assign hex1 = seg_q[1];
    assign hex2 = seg_q[2];
    assign hex3 = seg_q[3];
    assign hex4 = seg_q[4];
    assign hex5 = seg_q[5];

endmodule

// File: tb/tb_uart_byte_display.sv
// Self-checking bench for uart_byte_display with a short activity stretch.
module tb_uart_byte_display;

    localparam int act = 4;
    localparam int w   = 50;

    logic       clock   = 1'b0;
    logic       reset_n = 1'b1;
    logic       clear   = 1'b0;
    logic       hold    = 1'b0;
    logic [6:0] hex0, hex1, hex2, hex3, hex4, hex5;
    logic [7:0] byte_count;
    logic       led_activity;

    uart_byte_display_if bus ();

    uart_byte_display #(.activity_cycles(act)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .bus          (bus),
        .clear        (clear),
        .hold         (hold),
        .hex0         (hex0),
        .hex1         (hex1),
        .hex2         (hex2),
        .hex3         (hex3),
        .hex4         (hex4),
        .hex5         (hex5),
        .byte_count   (byte_count),
        .led_activity (led_activity)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    logic [w-1:0] exp_q[$];
    logic [7:0]   mh [3];
    logic [2:0]   mv;
    logic [7:0]   mcount;
    logic [w-1:0] exp_v;
    logic [w-1:0] blank_view;

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: glyph = 7'b1000000;  4'h1: glyph = 7'b1111001;
            4'h2: glyph = 7'b0100100;  4'h3: glyph = 7'b0110000;
            4'h4: glyph = 7'b0011001;  4'h5: glyph = 7'b0010010;
            4'h6: glyph = 7'b0000010;  4'h7: glyph = 7'b1111000;
            4'h8: glyph = 7'b0000000;  4'h9: glyph = 7'b0010000;
            4'hA: glyph = 7'b0001000;  4'hB: glyph = 7'b0000011;
            4'hC: glyph = 7'b1000110;  4'hD: glyph = 7'b0100001;
            4'hE: glyph = 7'b0000110;  default: glyph = 7'b0001110;
        endcase
    endfunction

    function automatic logic [13:0] slot_view(input int i);
        if (mv[i]) slot_view = {glyph(mh[i][7:4]), glyph(mh[i][3:0])};
        else       slot_view = 14'h3FFF;
    endfunction

    function automatic logic [w-1:0] expected_view();
        expected_view = {slot_view(2), slot_view(1), slot_view(0), mcount};
    endfunction

    function automatic logic [w-1:0] observed();
        observed = {hex5, hex4, hex3, hex2, hex1, hex0, byte_count};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) mh[i] = 8'h00;
        mv     = 3'b000;
        mcount = 8'h00;
    endtask

    task automatic apply_model(input logic rdy, input logic [7:0] d, input logic h, input logic c);
        if (rdy && c) begin
            mh[0] = d; mv = 3'b001; mcount = 8'd1;
        end else if (c) begin
            mv = 3'b000; mcount = 8'd0;
        end else if (rdy) begin
            mcount = mcount + 8'd1;
            if (!h) begin
                mh[2] = mh[1]; mh[1] = mh[0]; mh[0] = d;
                mv = {mv[1:0], 1'b1};
            end
        end
    endtask

    // One operation: drive at a falling edge, accept at edge N, return at the
    // falling edge after N+1 when the display reflects it.
    task automatic drive_op(input logic rdy, input logic [7:0] d, input logic h, input logic c);
        @(negedge clock);
        bus.byte_ready = rdy;
        bus.byte_data  = d;
        hold           = h;
        clear          = c;
        apply_model(rdy, d, h, c);
        exp_q.push_back(expected_view());
        @(negedge clock);
        bus.byte_ready = 1'b0;
        bus.byte_data  = 8'h00;
        clear          = 1'b0;
        @(negedge clock);
        hold = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clock);
        total++;
        if (observed() !== blank_view) begin
            bad++; $display("FAIL reset_held got=%h exp=%h", observed(), blank_view);
        end
        total++;
        if (led_activity !== 1'b0) begin
            bad++; $display("FAIL reset_held_led got=%b exp=0", led_activity);
        end
        reset_n = 1'b0;
        model_reset();
        repeat (3) @(negedge clock);
        total++;
        if (observed() !== blank_view) begin
            bad++; $display("FAIL reset_idle got=%h exp=%h", observed(), blank_view);
        end
        total++;
        if (led_activity !== 1'b0) begin
            bad++; $display("FAIL reset_idle_led got=%b exp=0", led_activity);
        end
    endtask

    task automatic test_single();
        int highs;
        drive_op(1'b1, 8'h3C, 1'b0, 1'b0);
        exp_v = exp_q.pop_front();
        total++;
        if (observed() !== exp_v) begin
            bad++; $display("FAIL single_view got=%h exp=%h", observed(), exp_v);
        end
        total++;
        if ({hex1, hex0, byte_count} !== {7'b0110000, 7'b1000110, 8'd1}) begin
            bad++; $display("FAIL single_digits got=%b_%b_%0d exp=0110000_1000110_1", hex1, hex0, byte_count);
        end
        highs = 0;
        while (led_activity === 1'b1 && highs < 20) begin
            highs++;
            @(negedge clock);
        end
        total++;
        if (highs !== act) begin
            bad++; $display("FAIL led_stretch got=%0d exp=%0d", highs, act);
        end
        repeat (2) @(negedge clock);
        total++;
        if (led_activity !== 1'b0) begin
            bad++; $display("FAIL led_off got=%b exp=0", led_activity);
        end
    endtask

    task automatic test_history();
        logic [7:0] seq [4];
        seq[0] = 8'h12; seq[1] = 8'hAB; seq[2] = 8'hF0; seq[3] = 8'h55;
        drive_op(1'b0, 8'h00, 1'b0, 1'b1);
        exp_v = exp_q.pop_front();
        total++;
        if (observed() !== exp_v) begin
            bad++; $display("FAIL hist_clear got=%h exp=%h", observed(), exp_v);
        end
        for (int i = 0; i < 4; i++) begin
            drive_op(1'b1, seq[i], 1'b0, 1'b0);
            exp_v = exp_q.pop_front();
            total++;
            if (observed() !== exp_v) begin
                bad++; $display("FAIL hist_step%0d got=%h exp=%h", i, observed(), exp_v);
            end
        end
        total++;
        if ({hex5, hex4, hex3, hex2, hex1, hex0, byte_count} !==
            {7'b0001000, 7'b0000011, 7'b0001110, 7'b1000000, 7'b0010010, 7'b0010010, 8'd4}) begin
            bad++; $display("FAIL hist_final got=%h", observed());
        end
    endtask

    task automatic test_hold();
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            bus.byte_ready = 1'b1;
            bus.byte_data  = 8'h77 + 8'(k);
            hold           = 1'b1;
            apply_model(1'b1, bus.byte_data, 1'b1, 1'b0);
            exp_q.push_back(expected_view());
            @(negedge clock);
            bus.byte_ready = 1'b0;
            if (k > 0) begin
                total++;
                if (led_activity !== 1'b1) begin
                    bad++; $display("FAIL hold_led_gap%0d got=%b exp=1", k, led_activity);
                end
            end
            @(negedge clock);
            total++;
            if (led_activity !== 1'b1) begin
                bad++; $display("FAIL hold_led%0d got=%b exp=1", k, led_activity);
            end
            exp_v = exp_q.pop_front();
            total++;
            if (observed() !== exp_v) begin
                bad++; $display("FAIL hold_view%0d got=%h exp=%h", k, observed(), exp_v);
            end
        end
        hold = 1'b0;
        drive_op(1'b1, 8'h6D, 1'b0, 1'b0);
        exp_v = exp_q.pop_front();
        total++;
        if (observed() !== exp_v) begin
            bad++; $display("FAIL hold_release got=%h exp=%h", observed(), exp_v);
        end
    endtask

    task automatic test_clear();
        drive_op(1'b1, 8'hE9, 1'b0, 1'b1);
        exp_v = exp_q.pop_front();
        total++;
        if (observed() !== exp_v) begin
            bad++; $display("FAIL clear_strobe got=%h exp=%h", observed(), exp_v);
        end
        total++;
        if ({hex5, hex4, hex3, hex2, hex1, hex0, byte_count} !==
            {28'hFFFFFFF, 7'b0000110, 7'b0010000, 8'd1}) begin
            bad++; $display("FAIL clear_e9 got=%h", observed());
        end
        drive_op(1'b1, 8'h4B, 1'b0, 1'b0);
        exp_v = exp_q.pop_front();
        drive_op(1'b1, 8'h5A, 1'b1, 1'b1);
        exp_v = exp_q.pop_front();
        total++;
        if (observed() !== exp_v) begin
            bad++; $display("FAIL clear_over_hold got=%h exp=%h", observed(), exp_v);
        end
        drive_op(1'b0, 8'h00, 1'b0, 1'b1);
        exp_v = exp_q.pop_front();
        total++;
        if (observed() !== exp_v || observed() !== blank_view) begin
            bad++; $display("FAIL clear_alone got=%h exp=%h", observed(), blank_view);
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 255; i++) begin
            drive_op(1'b1, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b0);
            exp_v = exp_q.pop_front();
            total++;
            if (observed() !== exp_v) begin
                bad++; $display("FAIL wrap_fill%0d got=%h exp=%h", i, observed(), exp_v);
            end
        end
        total++;
        if (byte_count !== 8'd255) begin
            bad++; $display("FAIL wrap_255 got=%0d exp=255", byte_count);
        end
        drive_op(1'b1, 8'h0F, 1'b0, 1'b0);
        exp_v = exp_q.pop_front();
        total++;
        if (observed() !== exp_v || byte_count !== 8'd0) begin
            bad++; $display("FAIL wrap_zero got=%h exp=%h", observed(), exp_v);
        end
    endtask

    task automatic test_reset_mid();
        drive_op(1'b1, 8'hC7, 1'b0, 1'b0);
        exp_v = exp_q.pop_front();
        total++;
        if (observed() !== exp_v || led_activity !== 1'b1) begin
            bad++; $display("FAIL mid_pre got=%h/%b exp=%h/1", observed(), led_activity, exp_v);
        end
        @(posedge clock);
        #2 reset_n = 1'b1;
        #1;
        total++;
        if (observed() !== blank_view || led_activity !== 1'b0) begin
            bad++; $display("FAIL mid_async got=%h/%b exp=%h/0", observed(), led_activity, blank_view);
        end
        repeat (2) @(negedge clock);
        reset_n = 1'b0;
        model_reset();
        drive_op(1'b1, 8'h81, 1'b0, 1'b0);
        exp_v = exp_q.pop_front();
        total++;
        if (observed() !== exp_v || byte_count !== 8'd1) begin
            bad++; $display("FAIL mid_after got=%h exp=%h", observed(), exp_v);
        end
    endtask

    initial begin
        bus.byte_ready = 1'b0;
        bus.byte_data  = 8'h00;
        blank_view     = {42'h3FF_FFFF_FFFF, 8'h00};
        model_reset();
        test_reset();
        test_single();
        test_history();
        test_hold();
        test_clear();
        test_wrap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_byte_display.md
Name: uart_byte_display

Overview:
- Downstream consumer of the UART receiver's byte_data/byte_ready strobe.
- Keeps a history of the last three received bytes and shows them as hex on six active-low seven-segment digits.
- Also provides a wrapping received-byte counter and a pulse-stretched activity LED.
- Sits between the receiver and the board display/LED pins in the byte-display top level.

Parameters:
- activity_cycles, 5000000, clock cycles the activity LED stays lit after the last byte (>=1). 100 ms at 50 MHz.

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous, active-high reset
- byte_data  in  8  received byte; valid only while byte_ready=1
- byte_ready  in  1  single-cycle strobe from the receiver
- clear  in  1  synchronous clear of history and count, level-sampled
- hold  in  1  1 = freeze the history (count and LED still update)
- hex0 .. hex5  out  7 each  active-low segments, bit0=a .. bit6=g. hex1:hex0 = newest byte (hi:lo nibble), hex3:hex2 = previous byte, hex5:hex4 = oldest.
- byte_count  out  8  number of bytes received since reset/clear, mod 256
- led_activity  out  1  high while the stretch counter is non-zero

Behaviour:
- Reset (reset_n=1, async): all history bytes 0, all valid flags 0, byte_count 0, stretch counter 0, led_activity 0, all hex outputs 7'h7F (blank). Outputs hold these values while reset is held.
- History is three 8-bit slots (s0 newest, s1, s2), each with a valid flag.
- Accept at edge N when byte_ready=1 and hold=0 and clear=0:
  - s2<=s1, s1<=s0, s0<=byte_data
  - valid2<=valid1, valid1<=valid0, valid0<=1
- hold=1: history and valid flags unchanged. Accepted bytes are dropped from the display only.
- byte_count increments on every byte_ready edge regardless of hold; 255 wraps to 0.
- clear=1 without byte_ready: all valid flags 0, byte_count 0.
- clear=1 with byte_ready at the same edge:
  - s0<=byte_data, valid0<=1, valid1/valid2<=0, byte_count<=1
  - This applies even when hold=1 (clear overrides hold for the valid flags).
- Display path:
  - Hex outputs are registered decodes of the history registers.
  - A byte accepted at edge N appears on the hex outputs after edge N+1 (1-cycle latency).
  - A slot with valid=0 drives both of its digits to 7'h7F.
- Glyphs, active-low, g..a:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
  - blank=1111111
- Activity stretch counter (width = clog2(activity_cycles+1)):
  - byte_ready at edge N loads activity_cycles; this reload also retriggers an active count.
  - Otherwise the counter decrements while non-zero.
  - led_activity = registered (counter != 0). It goes high after edge N+1 and stays high for exactly activity_cycles cycles after the last strobe.
  - clear does not affect the counter.
- byte_ready held high for multiple cycles is treated as one byte per cycle (no edge detection); the receiver guarantees one-cycle strobes.
- Reset asserted mid-stream: immediate blanking. The first byte after release is the newest byte, count=1.

Decomposition:
- Shared package uart_display_pkg:
  - seg_blank constant (7'h7F)
  - 16-entry glyph constants
  - history depth constant (3)
- One sub-module: hex_to_seven_seg (4-bit nibble + valid -> 7-bit active-low segments, combinational). Instantiated six times; the output registers stay in uart_byte_display.

Test Plan:
- Reset then idle with activity_cycles=4 -> all hex = 7F, byte_count=0, led_activity=0.
- Send 8'h3C -> after edge N+1: hex1=0110000 ('3'), hex0=1000110 ('C'), hex2..hex5=7F, byte_count=1; led_activity high for exactly 4 cycles, then 0.
- Send 8'h12, 8'hAB, 8'hF0, 8'h55 -> display 55/F0/AB (hex1:hex0='5''5', hex3:hex2='F''0', hex5:hex4='A''b'); byte_count=4.
- hold=1 then send 8'h77 -> display unchanged, byte_count increments by 1. Strobes 3 cycles apart keep led_activity continuously high.
- clear and byte_ready=1 with 8'hE9 at the same edge -> only hex1:hex0 show 'E''9', others blank, byte_count=1. clear alone -> all blank, byte_count=0.
- Preload byte_count=255 by sending 255 bytes, then send one more -> byte_count=0. Assert reset_n mid-activity -> led_activity and all outputs at reset values immediately (asynchronously).
